// File: rtl/game_timer.sv
// game_timer: game-screen countdown timer.
// Divides clk down to a 1 Hz tick and counts time_left down from
// START_SECONDS. Supports start/restart, pause/resume and an optional
// bonus-time add, and flags expiry. All outputs are registered.
// Optional feature macro: GAME_TIMER_BONUS_EN enables the bonus adder and
// MAX_SECONDS saturation. Without it the bonus input is ignored.
module game_timer #(
    parameter int unsigned CLK_HZ        = 100_000_000,
    parameter int unsigned START_SECONDS = 180,
    parameter int unsigned BONUS_SECONDS = 15,
    parameter int unsigned MAX_SECONDS   = 5999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        pause,
    input  logic        bonus,
    output logic [15:0] time_left,
    output logic        running,
    output logic        expired,
    output logic        expire_pulse,
    output logic        sec_tick
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_TC  = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PRESC_ONE = PW'(1);
    // Preset value, clamped so a load can never exceed the ceiling.
    localparam logic [15:0] START_LOAD = (START_SECONDS > MAX_SECONDS) ?
                                         16'(MAX_SECONDS) : 16'(START_SECONDS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUNNING = 2'd1,
        S_PAUSED  = 2'd2,
        S_EXPIRED = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   time_left_q, time_left_d;
    logic          running_q, running_d;
    logic          expired_q, expired_d;
    logic          expire_pulse_q, expire_pulse_d;
    logic          sec_tick_q, sec_tick_d;
    logic          tick_due;

`ifdef GAME_TIMER_BONUS_EN
    localparam logic [16:0] BONUS17 = 17'(BONUS_SECONDS);
    localparam logic [16:0] MAX17   = 17'(MAX_SECONDS);
    localparam logic [15:0] MAX16   = 16'(MAX_SECONDS);

    logic bonus_take;

    // Clamp a 17-bit intermediate sum to the MAX_SECONDS ceiling.
    function automatic logic [15:0] sat_max(input logic [16:0] v);
        if (v > MAX17) begin
            return MAX16;
        end
        return v[15:0];
    endfunction
`else
    // Bonus input and its amount are intentionally unused in this build.
    logic        unused_bonus;
    logic [16:0] unused_bonus_cfg;
    assign unused_bonus     = bonus;
    assign unused_bonus_cfg = 17'(BONUS_SECONDS);
`endif

    // Next-state logic: start > pause > bonus/decrement.
    always_comb begin
        state_d        = state_q;
        presc_d        = presc_q;
        time_left_d    = time_left_q;
        sec_tick_d     = 1'b0;
        expire_pulse_d = 1'b0;
        tick_due       = (state_q == S_RUNNING) && (presc_q == PRESC_TC);
`ifdef GAME_TIMER_BONUS_EN
        bonus_take     = 1'b0;
`endif

        if (start) begin
            time_left_d = START_LOAD;
            presc_d     = '0;
            if (START_LOAD == 16'd0) begin
                state_d        = S_EXPIRED;
                expire_pulse_d = (state_q != S_EXPIRED);
            end else begin
                state_d = S_RUNNING;
            end
        end else begin
            // Every RUNNING cycle counts toward the second, including the
            // cycle in which a pause is sampled, so pauses never cost or
            // gain time.
            if (state_q == S_RUNNING) begin
                presc_d = tick_due ? '0 : presc_q + PRESC_ONE;
            end
            sec_tick_d = tick_due;

            if (pause) begin
                if (state_q == S_RUNNING) begin
                    state_d = S_PAUSED;
                end else if (state_q == S_PAUSED) begin
                    state_d = S_RUNNING;
                end
            end

`ifdef GAME_TIMER_BONUS_EN
            bonus_take = bonus && !pause && (state_q != S_EXPIRED);
            if (bonus_take) begin
                // Sum first so the 17-bit intermediate never wraps below 0.
                time_left_d = sat_max({1'b0, time_left_q} + BONUS17 - {16'd0, tick_due});
            end else if (tick_due) begin
                time_left_d = time_left_q - 16'd1;
            end
            // Reaching zero wins over a coincident pause so the count can
            // never resume at zero.
            if (tick_due && !bonus_take && (time_left_q == 16'd1)) begin
                state_d        = S_EXPIRED;
                expire_pulse_d = 1'b1;
            end
`else
            if (tick_due) begin
                time_left_d = time_left_q - 16'd1;
            end
            if (tick_due && (time_left_q == 16'd1)) begin
                state_d        = S_EXPIRED;
                expire_pulse_d = 1'b1;
            end
`endif
        end

        running_d = (state_d == S_RUNNING);
        expired_d = (state_d == S_EXPIRED);
    end

    // State, prescaler and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            presc_q        <= '0;
            time_left_q    <= START_LOAD;
            running_q      <= 1'b0;
            expired_q      <= 1'b0;
            expire_pulse_q <= 1'b0;
            sec_tick_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            presc_q        <= presc_d;
            time_left_q    <= time_left_d;
            running_q      <= running_d;
            expired_q      <= expired_d;
            expire_pulse_q <= expire_pulse_d;
            sec_tick_q     <= sec_tick_d;
        end
    end

    assign time_left    = time_left_q;
    assign running      = running_q;
    assign expired      = expired_q;
    assign expire_pulse = expire_pulse_q;
    assign sec_tick     = sec_tick_q;

endmodule

// File: tb/tb_game_timer.sv
// Testbench for game_timer with CLK_HZ=4, START_SECONDS=3, BONUS_SECONDS=2,
// MAX_SECONDS=5. Expectations follow GAME_TIMER_BONUS_EN the same way the
// design build does.
module tb_game_timer;

    localparam int CLK_HZ = 4;
    localparam int START  = 3;
    localparam int BONUS  = 2;
    localparam int MAXS   = 5;
`ifdef GAME_TIMER_BONUS_EN
    localparam bit BONUS_EN = 1'b1;
`else
    localparam bit BONUS_EN = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_EXP   = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        bonus = 1'b0;
    logic [15:0] time_left;
    logic        running;
    logic        expired;
    logic        expire_pulse;
    logic        sec_tick;

    int errors = 0;
    int checks = 0;

    // Reference model: seconds remaining, RUNNING cycles accumulated toward
    // the next second, and the timer mode.
    int m_t    = START;
    int m_acc  = 0;
    int m_mode = M_IDLE;
    bit m_tick = 1'b0;
    bit m_pulse = 1'b0;

    game_timer #(
        .CLK_HZ(CLK_HZ),
        .START_SECONDS(START),
        .BONUS_SECONDS(BONUS),
        .MAX_SECONDS(MAXS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .pause(pause),
        .bonus(bonus),
        .time_left(time_left),
        .running(running),
        .expired(expired),
        .expire_pulse(expire_pulse),
        .sec_tick(sec_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] got_vec();
        return {time_left, running, expired, expire_pulse, sec_tick};
    endfunction

    function automatic logic [19:0] model_vec();
        return {16'(m_t), m_mode == M_RUN, m_mode == M_EXP, m_pulse, m_tick};
    endfunction

    task automatic model_reset();
        m_t = START; m_acc = 0; m_mode = M_IDLE; m_tick = 0; m_pulse = 0;
    endtask

    // One clock of behaviour from the timer's rules.
    task automatic model_step(input bit s, input bit p, input bit b);
        bit tick;
        bit bon;
        m_tick = 0;
        m_pulse = 0;
        if (s) begin
            m_t = (START > MAXS) ? MAXS : START;
            m_acc = 0;
            if (m_t == 0) begin
                if (m_mode != M_EXP) m_pulse = 1;
                m_mode = M_EXP;
            end else begin
                m_mode = M_RUN;
            end
        end else begin
            tick = 0;
            if (m_mode == M_RUN) begin
                m_acc = m_acc + 1;
                if (m_acc == CLK_HZ) begin
                    m_acc = 0;
                    tick = 1;
                end
            end
            bon = BONUS_EN && b && !p && (m_mode != M_EXP);
            if (p && m_mode == M_RUN) m_mode = M_PAUSE;
            else if (p && m_mode == M_PAUSE) m_mode = M_RUN;
            m_tick = tick;
            if (bon) begin
                m_t = m_t - int'(tick) + BONUS;
                if (m_t > MAXS) m_t = MAXS;
            end else if (tick) begin
                m_t = m_t - 1;
                if (m_t == 0) begin
                    m_mode = M_EXP;
                    m_pulse = 1;
                end
            end
        end
    endtask

    // Present inputs for one edge, advance the model, settle 1 time unit.
    task automatic drive(input bit s, input bit p, input bit b);
        start = s; pause = p; bonus = b;
        @(posedge clk);
        model_step(s, p, b);
        #1;
        start = 0; pause = 0; bonus = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        model_reset();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (got_vec() !== {16'd3, 4'b0000}) begin
            errors++;
            $display("FAIL reset_values: got %h want %h", got_vec(), {16'd3, 4'b0000});
        end
        reset = 1'b1;
        drive(0, 0, 0);
        checks++;
        if (got_vec() !== model_vec()) begin
            errors++;
            $display("FAIL reset_idle: got %h want %h", got_vec(), model_vec());
        end
    endtask

    task automatic test_countdown();
        int ticks = 0;
        do_reset();
        drive(1, 0, 0);
        checks++;
        if (time_left !== 16'd3 || running !== 1'b1) begin
            errors++;
            $display("FAIL countdown_start: got t=%0d run=%0d want t=3 run=1", time_left, running);
        end
        for (int k = 1; k <= 14; k++) begin
            drive(0, 0, 0);
            if (sec_tick) ticks++;
            checks++;
            if (got_vec() !== model_vec()) begin
                errors++;
                $display("FAIL countdown_cycle%0d: got %h want %h", k, got_vec(), model_vec());
            end
            if (k == 12) begin
                checks++;
                if ({time_left, expired, expire_pulse, sec_tick} !== {16'd0, 3'b111}) begin
                    errors++;
                    $display("FAIL countdown_expiry: got t=%0d exp=%0d pulse=%0d tick=%0d want 0 1 1 1",
                             time_left, expired, expire_pulse, sec_tick);
                end
            end
            if (k == 13) begin
                checks++;
                if ({running, expired, expire_pulse} !== 3'b010) begin
                    errors++;
                    $display("FAIL countdown_after: got run=%0d exp=%0d pulse=%0d want 0 1 0",
                             running, expired, expire_pulse);
                end
            end
        end
        checks++;
        if (ticks != 3) begin
            errors++;
            $display("FAIL countdown_ticks: got %0d want 3", ticks);
        end
    endtask

    task automatic test_pause();
        int first_tick = -1;
        do_reset();
        drive(1, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            drive(0, (k == 3) || (k == 13), 0);
            if (sec_tick && first_tick < 0) first_tick = k;
            if (k < 14) begin
                checks++;
                if (time_left !== 16'd3) begin
                    errors++;
                    $display("FAIL pause_hold%0d: got %0d want 3", k, time_left);
                end
            end
            checks++;
            if (got_vec() !== model_vec()) begin
                errors++;
                $display("FAIL pause_cycle%0d: got %h want %h", k, got_vec(), model_vec());
            end
        end
        checks++;
        if (first_tick != 14) begin
            errors++;
            $display("FAIL pause_first_tick: got cycle %0d want 14", first_tick);
        end
    endtask

    task automatic test_bonus_idle();
        do_reset();
        drive(0, 0, 1);
        checks++;
        if (time_left !== (BONUS_EN ? 16'd5 : 16'd3)) begin
            errors++;
            $display("FAIL bonus_idle1: got %0d want %0d", time_left, BONUS_EN ? 5 : 3);
        end
        drive(0, 0, 1);
        checks++;
        if (time_left !== (BONUS_EN ? 16'd5 : 16'd3) || running !== 1'b0) begin
            errors++;
            $display("FAIL bonus_idle_sat: got %0d run=%0d want %0d run=0", time_left, running,
                     BONUS_EN ? 5 : 3);
        end
    endtask

    task automatic test_bonus_tick();
        do_reset();
        drive(1, 0, 0);
        for (int k = 1; k <= 3; k++) drive(0, 0, 0);
        drive(0, 0, 1);
        checks++;
        if (time_left !== (BONUS_EN ? 16'd4 : 16'd2) || sec_tick !== 1'b1 || expired !== 1'b0) begin
            errors++;
            $display("FAIL bonus_tick: got t=%0d tick=%0d exp=%0d want t=%0d tick=1 exp=0",
                     time_left, sec_tick, expired, BONUS_EN ? 4 : 2);
        end
        checks++;
        if (got_vec() !== model_vec()) begin
            errors++;
            $display("FAIL bonus_tick_model: got %h want %h", got_vec(), model_vec());
        end
    endtask

    task automatic test_expired_bonus();
        do_reset();
        drive(1, 0, 0);
        for (int k = 1; k <= 12; k++) drive(0, 0, 0);
        drive(0, 0, 1);
        checks++;
        if (time_left !== 16'd0 || expired !== 1'b1) begin
            errors++;
            $display("FAIL expired_bonus: got t=%0d exp=%0d want t=0 exp=1", time_left, expired);
        end
        drive(1, 0, 0);
        checks++;
        if ({time_left, running, expired} !== {16'd3, 2'b10}) begin
            errors++;
            $display("FAIL expired_restart: got t=%0d run=%0d exp=%0d want 3 1 0",
                     time_left, running, expired);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1, 0, 0);
        for (int k = 1; k <= 6; k++) drive(0, 0, 0);
        checks++;
        if (time_left !== 16'd2 || running !== 1'b1) begin
            errors++;
            $display("FAIL async_pre: got t=%0d run=%0d want t=2 run=1", time_left, running);
        end
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (got_vec() !== {16'd3, 4'b0000}) begin
            errors++;
            $display("FAIL async_reset: got %h want %h", got_vec(), {16'd3, 4'b0000});
        end
        model_reset();
        #2;
        reset = 1'b1;
        drive(0, 0, 0);
        checks++;
        if (got_vec() !== model_vec()) begin
            errors++;
            $display("FAIL async_release: got %h want %h", got_vec(), model_vec());
        end
    endtask

    task automatic test_random();
        bit s, p, b;
        do_reset();
        for (int k = 0; k < 600; k++) begin
            s = ($urandom_range(0, 39) == 0);
            p = ($urandom_range(0, 14) == 0);
            b = ($urandom_range(0, 7) == 0);
            drive(s, p, b);
            checks++;
            if (got_vec() !== model_vec()) begin
                errors++;
                $display("FAIL random_cycle%0d: got %h want %h (s=%0d p=%0d b=%0d)",
                         k, got_vec(), model_vec(), s, p, b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_pause();
        test_bonus_idle();
        test_bonus_tick();
        test_expired_bonus();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
